mem_copy_initiator: RTL and testbench

Memory-port initiator that performs block copies inside the simulation host memory. It accepts a copy command (source, destination, beat count) and drives the read and write channels of one port of the two-port memory model. Each returned read beat is written back one beat at a time, with one read issued per cycle. The block is used in the sim top to stage and relocate host buffers without testbench tasks touching the memory array.

---
 rtl/mem_copy_initiator.sv | 167 ++++++++++++++++
 tb/tb_mem_copy_initiator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_initiator.sv
// rtl/mem_copy_initiator.sv - block-copy initiator driving one port of the host memory model
// Optional feature macro: MEM_COPY_FILL_EN (adds a pattern-fill command mode)
module mem_copy_initiator #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 64,
  parameter int LEN_WIDTH       = 16,
  parameter int MASK_WIDTH      = DATA_WIDTH / 8,
  parameter int ADDR_ALIGN_BITS = $clog2(MASK_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
`ifdef MEM_COPY_FILL_EN
  input  logic                  cmd_fill,
  input  logic [DATA_WIDTH-1:0] cmd_fill_data,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_data_vld,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [MASK_WIDTH-1:0] mem_wr_datastrb,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << ADDR_ALIGN_BITS) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_rd_cnt;
  logic [LEN_WIDTH-1:0]  r_wr_cnt;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [MASK_WIDTH-1:0] r_wr_strb;
  logic                  w_accept;
`ifdef MEM_COPY_FILL_EN
  logic                  r_fill;
  logic [DATA_WIDTH-1:0] r_fill_data;
`endif

  // Beat index to byte offset; wraps naturally in ADDR_WIDTH arithmetic.
  function automatic logic [ADDR_WIDTH-1:0] beat_off(input logic [LEN_WIDTH-1:0] cnt);
    return ADDR_WIDTH'(cnt) << ADDR_ALIGN_BITS;
  endfunction

  assign w_accept        = cmd_valid && (r_state == S_IDLE);
  assign mem_wr_data     = r_wr_data;
  assign mem_wr_addr     = r_wr_addr;
  assign mem_wr_datastrb = r_wr_strb;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_next_state = r_state;
    cmd_ready    = rst_n && (r_state == S_IDLE);
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    mem_rd_en    = 1'b0;
    mem_rd_addr  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = (cmd_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
`ifdef MEM_COPY_FILL_EN
        // Fill finishes when the write now on the port is the last one.
        if (r_fill) begin
          if (r_wr_cnt == r_len) w_next_state = S_DONE;
        end else
`endif
        begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = r_src + beat_off(r_rd_cnt);
          if (r_rd_cnt == r_len - LEN_WIDTH'(1)) w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // r_wr_cnt already counts the write currently presented.
        if ((r_wr_strb != '0) && (r_wr_cnt == r_len)) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Command latch, read counter and registered write channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
      r_wr_strb <= '0;
`ifdef MEM_COPY_FILL_EN
      r_fill      <= 1'b0;
      r_fill_data <= '0;
`endif
    end else begin
      r_wr_strb <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_src    <= cmd_src_addr & ALIGN_MASK;
            r_dst    <= cmd_dst_addr & ALIGN_MASK;
            r_len    <= cmd_len;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
`ifdef MEM_COPY_FILL_EN
            r_fill      <= cmd_fill;
            r_fill_data <= cmd_fill_data;
            // Fill needs no read latency, so the first write goes out right away.
            if (cmd_fill && (cmd_len != '0)) begin
              r_wr_data <= cmd_fill_data;
              r_wr_addr <= cmd_dst_addr & ALIGN_MASK;
              r_wr_strb <= '1;
              r_wr_cnt  <= LEN_WIDTH'(1);
            end
`endif
          end
        end
        S_RUN, S_DRAIN: begin
`ifdef MEM_COPY_FILL_EN
          if (r_fill) begin
            if (r_wr_cnt != r_len) begin
              r_wr_data <= r_fill_data;
              r_wr_addr <= r_dst + beat_off(r_wr_cnt);
              r_wr_strb <= '1;
              r_wr_cnt  <= r_wr_cnt + LEN_WIDTH'(1);
            end
          end else
`endif
          begin
            if (r_state == S_RUN) r_rd_cnt <= r_rd_cnt + LEN_WIDTH'(1);
            if (mem_rd_data_vld) begin
              r_wr_data <= mem_rd_data;
              r_wr_addr <= r_dst + beat_off(r_wr_cnt);
              r_wr_strb <= '1;
              r_wr_cnt  <= r_wr_cnt + LEN_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_initiator.sv
// tb/tb_mem_copy_initiator.sv - directed self-checking bench for mem_copy_initiator
module tb_mem_copy_initiator;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int LW = 16;
  localparam int MW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src_addr;
  logic [AW-1:0] cmd_dst_addr;
  logic [LW-1:0] cmd_len;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_data_vld;
  logic [DW-1:0] mem_wr_data;
  logic [MW-1:0] mem_wr_datastrb;
  logic [AW-1:0] mem_wr_addr;
`ifdef MEM_COPY_FILL_EN
  logic          cmd_fill;
  logic [DW-1:0] cmd_fill_data;
`endif

  always #5 clk = ~clk;

  mem_copy_initiator dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_src_addr    (cmd_src_addr),
    .cmd_dst_addr    (cmd_dst_addr),
    .cmd_len         (cmd_len),
`ifdef MEM_COPY_FILL_EN
    .cmd_fill        (cmd_fill),
    .cmd_fill_data   (cmd_fill_data),
`endif
    .busy            (busy),
    .done            (done),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data),
    .mem_rd_data_vld (mem_rd_data_vld),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_datastrb (mem_wr_datastrb),
    .mem_wr_addr     (mem_wr_addr)
  );

  // Memory model: 1-cycle read latency, read-before-write on the same edge.
  logic [DW-1:0] mem [0:1023];
  logic          pl_en;
  logic [9:0]    pl_idx;
  logic [DW-1:0] pl_data;
  int            rd_count = 0;
  int            wr_count = 0;
  logic [AW-1:0] last_rd_addr;
  logic [AW-1:0] last_wr_addr;

  always @(posedge clk) begin
    mem_rd_data_vld <= mem_rd_en;
    if (mem_rd_en) begin
      mem_rd_data  <= mem[mem_rd_addr[15:6]];
      rd_count     <= rd_count + 1;
      last_rd_addr <= mem_rd_addr;
    end
    if (mem_wr_datastrb != '0) begin
      mem[mem_wr_addr[15:6]] <= mem_wr_data;
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_wr_addr;
    end
    if (pl_en) mem[pl_idx] <= pl_data;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [63:0] val);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = DW'(val);
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  // Issue a command and return the cycle (relative to the accept edge) done is seen.
  task automatic run_cmd(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [LW-1:0] len, output int lat);
    cmd_src_addr = src;
    cmd_dst_addr = dst;
    cmd_len      = len;
    cmd_valid    = 1'b1;
    @(posedge clk); #1;
    cmd_valid    = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},    64'(busy),             64'd0);
    chk({tag, "_done"},    64'(done),             64'd0);
    chk({tag, "_rd_en"},   64'(mem_rd_en),        64'd0);
    chk({tag, "_rd_addr"}, mem_rd_addr,           64'd0);
    chk({tag, "_strb"},    mem_wr_datastrb,       64'd0);
    chk({tag, "_wr_addr"}, mem_wr_addr,           64'd0);
    chk({tag, "_wr_data"}, 64'(|mem_wr_data),     64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int r0;
    int w0;
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_src_addr = '0;
    cmd_dst_addr = '0;
    cmd_len      = '0;
    pl_en        = 1'b0;
    pl_idx       = '0;
    pl_data      = '0;
`ifdef MEM_COPY_FILL_EN
    cmd_fill      = 1'b0;
    cmd_fill_data = '0;
`endif

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ready_in_reset", 64'(cmd_ready), 64'd0);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 4; i++)  preload(10'(64 + i), 64'(i));
    for (int i = 0; i < 8; i++)  preload(10'(i), 64'(i));
    for (int i = 0; i < 16; i++) preload(10'(256 + i), 64'(100 + i));

    // Basic copy
    r0 = rd_count; w0 = wr_count;
    run_cmd(64'h1000, 64'h2000, 16'd4, lat);
    chk("basic_done_lat", 64'(lat), 64'd7);
    @(posedge clk); #1;
    chk("basic_ready_back", 64'(cmd_ready), 64'd1);
    chk("basic_busy_clear", 64'(busy), 64'd0);
    chk("basic_reads", 64'(rd_count - r0), 64'd4);
    chk("basic_writes", 64'(wr_count - w0), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("basic_beat%0d", i), mem[128 + i][63:0], 64'(i));

    // Misaligned addresses
    r0 = rd_count; w0 = wr_count;
    run_cmd(64'h1013, 64'h2027, 16'd1, lat);
    chk("misal_done_lat", 64'(lat), 64'd4);
    @(posedge clk); #1;
    chk("misal_rd_addr", last_rd_addr, 64'h1000);
    chk("misal_wr_addr", last_wr_addr, 64'h2000);
    chk("misal_reads", 64'(rd_count - r0), 64'd1);
    chk("misal_writes", 64'(wr_count - w0), 64'd1);

    // Zero length
    r0 = rd_count; w0 = wr_count;
    run_cmd(64'h1000, 64'h2000, 16'd0, lat);
    chk("zero_done_lat", 64'(lat), 64'd1);
    @(posedge clk); #1;
    chk("zero_ready_back", 64'(cmd_ready), 64'd1);
    chk("zero_reads", 64'(rd_count - r0), 64'd0);
    chk("zero_writes", 64'(wr_count - w0), 64'd0);

    // Overlapping copy, destination above source
    run_cmd(64'h0000, 64'h0040, 16'd7, lat);
    chk("ovl_done_lat", 64'(lat), 64'd10);
    @(posedge clk); #1;
    chk("ovl_beat0", mem[0][63:0], 64'd0);
    for (int i = 0; i < 7; i++) chk($sformatf("ovl_beat%0d", i + 1), mem[i + 1][63:0], 64'(i));

    // Reset three cycles into a 16-beat copy
    cmd_src_addr = 64'h4000;
    cmd_dst_addr = 64'h5000;
    cmd_len      = 16'd16;
    cmd_valid    = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready_low", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    w0 = wr_count;
    chk_reset_outputs("midrst");
    chk("midrst_ready_back", 64'(cmd_ready), 64'd1);
    repeat (6) begin @(posedge clk); #1; end
    chk("midrst_no_writes", 64'(wr_count - w0), 64'd0);
    chk("midrst_idle", 64'(busy), 64'd0);

    // Normal operation after the abandoned command
    run_cmd(64'h4000, 64'h6000, 16'd2, lat);
    chk("post_done_lat", 64'(lat), 64'd5);
    @(posedge clk); #1;
    chk("post_beat0", mem[384][63:0], 64'd100);
    chk("post_beat1", mem[385][63:0], 64'd101);

`ifdef MEM_COPY_FILL_EN
    // Fill mode
    r0 = rd_count; w0 = wr_count;
    cmd_fill      = 1'b1;
    cmd_fill_data = {64{8'hA5}};
    run_cmd(64'h1000, 64'h3000, 16'd2, lat);
    cmd_fill      = 1'b0;
    chk("fill_done_lat", 64'(lat), 64'd3);
    @(posedge clk); #1;
    chk("fill_reads", 64'(rd_count - r0), 64'd0);
    chk("fill_writes", 64'(wr_count - w0), 64'd2);
    chk("fill_beat0", mem[192][63:0], 64'hA5A5A5A5A5A5A5A5);
    chk("fill_beat1", mem[193][63:0], 64'hA5A5A5A5A5A5A5A5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
